anton_neopixel_decoder: RTL
===========================

Name: anton_neopixel_decoder

Overview:
- Receiver for the WS2812/NeoPixel single-wire stream that the transmitter drives on neoData.
- Samples the line on clk7mhz, classifies each high pulse as a 0 or 1 bit, and assembles bits MSB-first into bytes.
- Emits each byte with a write strobe and a byte index, so the output can fill a pixel buffer, and flags the end of each frame when it detects the low reset gap.
- Used for loopback self-test of the transmitter and for daisy-chain monitoring.

Parameters:
- BUFFER_END, `BUFFER_END_DEFAULT: last valid byte index. The index width is BUFFER_BITS = `CLOG2(BUFFER_END+1).
- BIT_THRESHOLD, 4: high-pulse width in clk7mhz ticks at or above which the bit decodes as 1; below it decodes as 0.
- MAX_HIGH, 12: a high pulse longer than this many ticks is a protocol error.
- RESET_DETECT, 300: low time in ticks (~43us) that counts as a frame reset gap.

Ports:
- clk7mhz  input  1  sole clock, 7MHz.
- reset  input  1  synchronous reset, active-high.
- neoDataIn  input  1  asynchronous NeoPixel line.
- enable  input  1  decoding enabled; when low the block is held in SYNC.
- byteData  output  8  last assembled byte.
- byteValid  output  1  one-cycle strobe; byteData and byteIndex are valid.
- byteIndex  output  BUFFER_BITS  position of the byte within the current frame.
- frameSync  output  1  one-cycle pulse when a reset gap ends a frame that contained at least one bit.
- frameBytes  output  BUFFER_BITS+1  byte count of the last completed frame, held until the next frameSync.
- errorPulse  output  1  one-cycle pulse on a protocol error.
- overflow  output  1  sticky; a byte was dropped beyond BUFFER_END. Cleared at the start of the next frame.
- neoRxState  output  1  0 = receiving bits, 1 = idle/reset gap.

Behaviour:
- Reset values: all outputs 0, except neoRxState = 1. State = SYNC; all counters and the shift register are 0.
- Input path: neoDataIn passes through a 2-flop synchronizer. Edges are detected on the synchronized signal s.
- SYNC:
  - Count consecutive low cycles of s in a 10-bit saturating counter. A high cycle clears it.
  - When count reaches RESET_DETECT, go to GAP.
  - This stops the block from decoding mid-frame after reset or enable.
- GAP:
  - neoRxState = 1.
  - A rising edge of s goes to HIGH, clears bitCount, byteIndex and overflow, and sets the high counter to 1.
- HIGH:
  - Count high cycles in a 4-bit saturating counter.
  - If the count exceeds MAX_HIGH: errorPulse, discard the partial byte, go to SYNC.
  - On a falling edge: bit = (count >= BIT_THRESHOLD). Shift the bit in MSB-first and go to LOW, with the low counter at 1.
- LOW:
  - A rising edge goes to HIGH.
  - If the low count reaches RESET_DETECT: go to GAP. If bitCount != 0, pulse errorPulse and discard the partial byte. Pulse frameSync and latch frameBytes = number of bytes seen.
- Byte completion:
  - On the 8th bit, byteValid is high on the cycle after the falling edge is seen on s, with byteData = the assembled byte.
  - Total latency is 3 cycles after the falling edge on neoDataIn.
  - byteIndex then increments.
  - If byteIndex would exceed BUFFER_END: suppress byteValid, set overflow, and keep counting frameBytes. frameBytes saturates at BUFFER_END+1.
- Simultaneous events: reset and enable low take priority over everything. A byte completing at the frame end is emitted before frameSync (frameSync comes at least RESET_DETECT cycles later).
- enable falling mid-frame: return to SYNC at once, with no strobes.

Optional Feature:
- Macro: ANTON_NEOPIXEL_DECODER_GLITCH_EN.
- Defined: a 3-sample majority filter sits after the synchronizer. Single-cycle spikes are rejected and all latencies grow by 1 cycle.
- Undefined: s is the raw synchronizer output.

Decomposition:
- anton_common.vh gains the decoder state encodings `ENUM_DEC_STATE_SYNC/GAP/HIGH/LOW and the default tick constants.
- Sub-module anton_neopixel_pulse_meter: holds the synchronizer, the optional glitch filter, edge detection, and the saturating high/low width counters.
- Bit classification and byte assembly stay in the top module.

Test Plan:
- Line idle low for 400 cycles, then the bit patterns for 0xA5 and 0x3C (0 = 2 high/6 low, 1 = 5 high/3 low), then low 400 cycles
  -> byteValid twice: (0xA5, idx 0) then (0x3C, idx 1); one frameSync; frameBytes = 2.
- Frame starts while reset is deasserting, with no preceding gap -> no byteValid until the first 300-cycle low gap; the next frame then decodes correctly.
- 5 bits then a gap -> errorPulse, no byteValid, frameSync with frameBytes = 0.
- High pulse of 20 cycles -> errorPulse, state returns to SYNC, following frame decodes normally.
- BUFFER_END=3, 6 bytes sent -> byteValid for idx 0..3 only; overflow = 1; frameBytes = 4; overflow clears on the next frame's first rising edge.
- Loopback from anton_neopixel_raw neoData with pixels 0x00, 0xFF, 0x81 -> identical bytes received; frameSync aligned with pixelsSync.
- With ANTON_NEOPIXEL_DECODER_GLITCH_EN, a 1-cycle spike inside the gap -> no state change.

Source files
------------

// File: rtl/anton_neopixel_decoder_pkg.sv
// -----------------------------------------------------------------------------
// anton_neopixel_decoder_pkg
// Shared types and constants for the NeoPixel stream decoder:
//   - dec_state_e : decoder state encoding (SYNC / GAP / HIGH / LOW)
//   - default tick constants for bit threshold, max high width, reset gap
//   - counter widths used by the pulse meter
//   - maj3()      : 3-input majority, used by the optional glitch filter
// Optional feature macro: ANTON_NEOPIXEL_DECODER_GLITCH_EN (see pulse meter).
// -----------------------------------------------------------------------------
package anton_neopixel_decoder_pkg;

   typedef enum logic [1:0] {
      DEC_SYNC = 2'd0,  // waiting for a clean reset gap before decoding
      DEC_GAP  = 2'd1,  // idle / reset gap, next rising edge starts a frame
      DEC_HIGH = 2'd2,  // measuring a high pulse
      DEC_LOW  = 2'd3   // between bits, watching for the next rise or a gap
   } dec_state_e;

   localparam int BUFFER_END_DEFAULT    = 63;
   localparam int BIT_THRESHOLD_DEFAULT = 4;
   localparam int MAX_HIGH_DEFAULT      = 12;
   localparam int RESET_DETECT_DEFAULT  = 300;

   localparam int HI_CNT_W = 4;
   localparam int LO_CNT_W = 10;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/anton_neopixel_pulse_meter.sv
// -----------------------------------------------------------------------------
// anton_neopixel_pulse_meter
// Line front end for the NeoPixel decoder: 2-flop synchronizer, optional
// 3-sample majority glitch filter, edge detection and saturating run-length
// counters for the high and low phases of the synchronized line s.
//
// Ports:
//   clk_i     in   sample clock (7MHz)
//   reset_i   in   synchronous reset, active-high
//   clear_i   in   zero the run counters (decoder disabled)
//   din_i     in   asynchronous NeoPixel line
//   rise_o    out  s rose this cycle
//   fall_o    out  s fell this cycle
//   hi_cnt_o  out  consecutive high cycles of s before this cycle (sat.)
//   lo_cnt_o  out  consecutive low cycles of s before this cycle (sat.)
//
// Macro ANTON_NEOPIXEL_DECODER_GLITCH_EN: when defined, s is the majority of
// the last three synchronizer samples, which rejects single-cycle spikes and
// delays every edge by one cycle.
// -----------------------------------------------------------------------------
module anton_neopixel_pulse_meter
   import anton_neopixel_decoder_pkg::*;
(
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                clear_i,
   input  logic                din_i,
   output logic                rise_o,
   output logic                fall_o,
   output logic [HI_CNT_W-1:0] hi_cnt_o,
   output logic [LO_CNT_W-1:0] lo_cnt_o
);

   logic                sync1_q, sync2_q, s_prev_q, s;
   logic [HI_CNT_W-1:0] hi_q, hi_d;
   logic [LO_CNT_W-1:0] lo_q, lo_d;

`ifdef ANTON_NEOPIXEL_DECODER_GLITCH_EN
   logic d1_q, d2_q;

   assign s = maj3(sync2_q, d1_q, d2_q);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         d1_q <= 1'b0;
         d2_q <= 1'b0;
      end else begin
         d1_q <= sync2_q;
         d2_q <= d1_q;
      end
   end
`else
   assign s = sync2_q;
`endif

   // Run lengths restart on every level change; the counter of the opposite
   // level reads back the full width of the phase that just ended.
   always_comb begin
      hi_d = '0;
      lo_d = '0;
      if (!clear_i) begin
         if (s) hi_d = (hi_q == '1) ? hi_q : hi_q + 1'b1;
         else   lo_d = (lo_q == '1) ? lo_q : lo_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         s_prev_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         sync1_q  <= din_i;
         sync2_q  <= sync1_q;
         s_prev_q <= s;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign rise_o   = s & ~s_prev_q;
   assign fall_o   = ~s & s_prev_q;
   assign hi_cnt_o = hi_q;
   assign lo_cnt_o = lo_q;

endmodule

// File: rtl/anton_neopixel_decoder.sv
// -----------------------------------------------------------------------------
// anton_neopixel_decoder
// WS2812/NeoPixel receiver. Classifies each high pulse as a 0/1 bit, packs bits
// MSB-first into bytes, strobes each byte with its index in the frame and
// flags the end of a frame on the low reset gap.
//
// Ports:
//   clk7mhz     in   sole clock, 7MHz
//   reset       in   synchronous reset, active-high
//   neoDataIn   in   asynchronous NeoPixel line
//   enable      in   decoding enabled; low holds the block in SYNC
//   byteData    out  last assembled byte
//   byteValid   out  1-cycle strobe, byteData/byteIndex valid
//   byteIndex   out  byte position within the current frame
//   frameSync   out  1-cycle pulse when a gap ends a frame with >=1 bit
//   frameBytes  out  byte count of last frame (saturates at BUFFER_END+1)
//   errorPulse  out  1-cycle pulse on a protocol error
//   overflow    out  sticky: byte dropped beyond BUFFER_END this frame
//   neoRxState  out  0 = receiving bits, 1 = idle/reset gap
//
// Optional macro ANTON_NEOPIXEL_DECODER_GLITCH_EN enables the spike filter in
// the pulse meter (adds one cycle to all latencies).
// -----------------------------------------------------------------------------
module anton_neopixel_decoder
   import anton_neopixel_decoder_pkg::*;
#(
   parameter  int BUFFER_END    = BUFFER_END_DEFAULT,
   parameter  int BIT_THRESHOLD = BIT_THRESHOLD_DEFAULT,
   parameter  int MAX_HIGH      = MAX_HIGH_DEFAULT,
   parameter  int RESET_DETECT  = RESET_DETECT_DEFAULT,
   localparam int BUFFER_BITS   = (BUFFER_END > 0) ? $clog2(BUFFER_END + 1) : 1
)(
   input  logic                   clk7mhz,
   input  logic                   reset,
   input  logic                   neoDataIn,
   input  logic                   enable,
   output logic [7:0]             byteData,
   output logic                   byteValid,
   output logic [BUFFER_BITS-1:0] byteIndex,
   output logic                   frameSync,
   output logic [BUFFER_BITS:0]   frameBytes,
   output logic                   errorPulse,
   output logic                   overflow,
   output logic                   neoRxState
);

   localparam logic [HI_CNT_W-1:0] THR_C  = HI_CNT_W'(BIT_THRESHOLD);
   localparam logic [HI_CNT_W-1:0] MAXH_C = HI_CNT_W'(MAX_HIGH);
   localparam logic [LO_CNT_W-1:0] GAP_C  = LO_CNT_W'(RESET_DETECT);
   localparam logic [BUFFER_BITS:0] FULL_C = (BUFFER_BITS + 1)'(BUFFER_END + 1);

   logic                rise, fall, bit_val;
   logic [HI_CNT_W-1:0] hi_cnt;
   logic [LO_CNT_W-1:0] lo_cnt;

   dec_state_e             state_q, state_d;
   logic [7:0]             shift_q, shift_d, data_q, data_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [BUFFER_BITS:0]   byte_cnt_q, byte_cnt_d, fbytes_q, fbytes_d;
   logic [BUFFER_BITS-1:0] idx_q, idx_d;
   logic                   valid_q, valid_d, fsync_q, fsync_d;
   logic                   err_q, err_d, ovf_q, ovf_d;

   anton_neopixel_pulse_meter u_meter (
      .clk_i    (clk7mhz),
      .reset_i  (reset),
      .clear_i  (~enable),
      .din_i    (neoDataIn),
      .rise_o   (rise),
      .fall_o   (fall),
      .hi_cnt_o (hi_cnt),
      .lo_cnt_o (lo_cnt)
   );

   assign bit_val = (hi_cnt >= THR_C);

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      data_d     = data_q;
      idx_d      = idx_q;
      fbytes_d   = fbytes_q;
      ovf_d      = ovf_q;
      valid_d    = 1'b0;
      fsync_d    = 1'b0;
      err_d      = 1'b0;
      if (!enable) begin
         state_d   = DEC_SYNC;
         shift_d   = '0;
         bit_cnt_d = '0;
      end else begin
         unique case (state_q)
            DEC_SYNC: if (lo_cnt >= GAP_C) state_d = DEC_GAP;
            DEC_GAP: begin
               if (rise) begin
                  state_d    = DEC_HIGH;
                  shift_d    = '0;
                  bit_cnt_d  = '0;
                  byte_cnt_d = '0;
                  ovf_d      = 1'b0;
               end
            end
            DEC_HIGH: begin
               // Over-long pulse wins even if it ends on this cycle.
               if (hi_cnt > MAXH_C) begin
                  state_d   = DEC_SYNC;
                  err_d     = 1'b1;
                  shift_d   = '0;
                  bit_cnt_d = '0;
               end else if (fall) begin
                  state_d   = DEC_LOW;
                  shift_d   = {shift_q[6:0], bit_val};
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7) begin
                     // byte_cnt_q saturates at FULL_C, so it doubles as the
                     // "buffer already full" flag.
                     if (byte_cnt_q < FULL_C) begin
                        valid_d    = 1'b1;
                        data_d     = {shift_q[6:0], bit_val};
                        idx_d      = byte_cnt_q[BUFFER_BITS-1:0];
                        byte_cnt_d = byte_cnt_q + 1'b1;
                     end else begin
                        ovf_d      = 1'b1;
                     end
                  end
               end
            end
            DEC_LOW: begin
               if (rise) begin
                  state_d = DEC_HIGH;
               end else if (lo_cnt >= GAP_C) begin
                  state_d  = DEC_GAP;
                  fsync_d  = 1'b1;
                  fbytes_d = byte_cnt_q;
                  if (bit_cnt_q != 3'd0) begin
                     err_d     = 1'b1;
                     shift_d   = '0;
                     bit_cnt_d = '0;
                  end
               end
            end
            default: state_d = DEC_SYNC;
         endcase
      end
   end

   always_ff @(posedge clk7mhz) begin
      if (reset) begin
         state_q    <= DEC_SYNC;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         data_q     <= '0;
         idx_q      <= '0;
         fbytes_q   <= '0;
         ovf_q      <= 1'b0;
         valid_q    <= 1'b0;
         fsync_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         data_q     <= data_d;
         idx_q      <= idx_d;
         fbytes_q   <= fbytes_d;
         ovf_q      <= ovf_d;
         valid_q    <= valid_d;
         fsync_q    <= fsync_d;
         err_q      <= err_d;
      end
   end

   assign byteData   = data_q;
   assign byteValid  = valid_q;
   assign byteIndex  = idx_q;
   assign frameSync  = fsync_q;
   assign frameBytes = fbytes_q;
   assign errorPulse = err_q;
   assign overflow   = ovf_q;
   assign neoRxState = (state_q == DEC_SYNC) || (state_q == DEC_GAP);

endmodule
